// File: rtl/fetch_queue.sv
// fetch_queue - instruction-fetch front end.
//
// Issues word fetches to a multi-cycle instruction memory over a req/ack
// handshake, buffers returned instructions together with their PC+4 in a
// DEPTH-entry FIFO, and presents the head entry to the IF/ID register.
// Handles pipeline stall (no pop) and branch/jump redirect (flush + restart).
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   mem_req      fetch request (registered), held until mem_ack
//   mem_addr     fetch address, word aligned (registered)
//   mem_ack      memory returned mem_rdata for the current request
//   mem_rdata    instruction word, valid with mem_ack
//   stall        IF/ID holds; head is not popped
//   redirect     taken branch/jump: flush queue, restart at redirect_pc
//   redirect_pc  new fetch address
//   instr_valid  head entry valid (queue not empty)
//   instr        head instruction, 0 when empty
//   pc4          head entry PC+4, 0 when empty
//
// Optional build macro FETCH_QUEUE_STATS_EN adds saturating counters:
//   stat_fetched  accepted pushes
//   stat_dropped  discarded acks plus entries flushed by redirect

module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] pc4
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0] stat_fetched,
    output logic [31:0] stat_dropped
`endif
);

    localparam int             AW      = $clog2(DEPTH);
    localparam int             CW      = AW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]    ALIGN   = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t        r_state, w_state_nxt;
    logic [31:0]   r_fetch_pc, w_fetch_pc_nxt;
    logic          r_mem_req, w_mem_req_nxt;
    logic [31:0]   r_mem_addr, w_mem_addr_nxt;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr, r_wr_ptr;
    logic [31:0]   r_instr_q [DEPTH];
    logic [31:0]   r_pc4_q   [DEPTH];

    logic          w_pop, w_push;
    logic [CW-1:0] w_count_pop;
    logic          w_space_idle, w_space_req;

    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_instr_q[r_rd_ptr] : 32'h0;
    assign pc4         = instr_valid ? r_pc4_q[r_rd_ptr]   : 32'h0;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;

    // Redirect suppresses the pop so the flushed head is never consumed.
    assign w_pop       = instr_valid & ~stall & ~redirect;
    assign w_count_pop = r_count - {{(CW-1){1'b0}}, w_pop};
    // Issue only when a slot is guaranteed for the single outstanding ack.
    assign w_space_idle = (w_count_pop < DEPTH_C);
    assign w_space_req  = ((w_count_pop + CW'(1)) < DEPTH_C);

    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_push         = 1'b0;
        case (r_state)
            IDLE: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc & ALIGN;
                end else if (w_space_idle) begin
                    w_state_nxt    = REQ;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = r_fetch_pc;
                end
            end
            REQ: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc & ALIGN;
                    if (mem_ack) begin
                        w_state_nxt   = IDLE;
                        w_mem_req_nxt = 1'b0;
                    end else begin
                        // In-flight request must still complete on the old address.
                        w_state_nxt = DROP;
                    end
                end else if (mem_ack) begin
                    w_push         = 1'b1;
                    w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    if (w_space_req) begin
                        w_mem_addr_nxt = r_fetch_pc + 32'd4;
                    end else begin
                        w_state_nxt   = IDLE;
                        w_mem_req_nxt = 1'b0;
                    end
                end
            end
            DROP: begin
                if (redirect) w_fetch_pc_nxt = redirect_pc & ALIGN;
                if (mem_ack) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC & ALIGN;
            r_mem_req  <= 1'b0;
            r_mem_addr <= RESET_PC & ALIGN;
            r_count    <= '0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt & ALIGN;
            if (redirect) begin
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
                if (w_push && !w_pop)      r_count <= r_count + CW'(1);
                else if (!w_push && w_pop) r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_q[r_wr_ptr] <= mem_rdata;
            r_pc4_q[r_wr_ptr]   <= r_fetch_pc + 32'd4;
        end
    end

`ifdef FETCH_QUEUE_STATS_EN
    logic        w_discard;
    logic [32:0] w_fetch_sum, w_drop_sum;

    // An ack is thrown away in DROP, or in REQ when redirect lands with it.
    assign w_discard   = mem_ack & ((r_state == DROP) | ((r_state == REQ) & redirect));
    assign w_fetch_sum = {1'b0, stat_fetched} + 33'(w_push);
    assign w_drop_sum  = {1'b0, stat_dropped}
                       + (redirect ? 33'(r_count) : 33'd0)
                       + 33'(w_discard);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_fetched <= '0;
            stat_dropped <= '0;
        end else begin
            stat_fetched <= w_fetch_sum[32] ? 32'hFFFF_FFFF : w_fetch_sum[31:0];
            stat_dropped <= w_drop_sum[32]  ? 32'hFFFF_FFFF : w_drop_sum[31:0];
        end
    end
`endif

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction-fetch front end. Replaces the direct single-cycle IMEM read with a req/ack handshake to a multi-cycle instruction memory.
- Buffers fetched instructions with their PC+4 in a small FIFO and presents them to the IF/ID pipeline register.
- Honours pipeline stall and branch/jump redirect. Sits between the instruction memory and IF/ID.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- mem_req  output  1  fetch request to instruction memory; registered
- mem_addr  output  32  fetch address, word aligned; registered
- mem_ack  input  1  memory has returned mem_rdata for the current request
- mem_rdata  input  32  instruction word, valid when mem_ack=1
- stall  input  1  pipeline hazard stall; IF/ID holds, so no pop
- redirect  input  1  taken branch or jump; flush and restart
- redirect_pc  input  32  new fetch address, valid when redirect=1
- instr_valid  output  1  head entry valid (FIFO not empty)
- instr  output  32  head instruction; 32'h0 (NOP) when empty
- pc4  output  32  head entry PC+4; 32'h0 when empty

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, fetch_pc=RESET_PC, FIFO count=0, rd/wr pointers=0, mem_req=0, mem_addr=RESET_PC, instr_valid=0, instr=0, pc4=0.
- Reset asserted mid-request abandons the transaction. Memory must tolerate mem_req dropping without ack.
- Handshake:
  - mem_req is held high with mem_addr stable until a cycle with mem_ack=1.
  - mem_ack is ignored while mem_req=0.
  - Minimum latency: ack in the first cycle mem_req is high.
- Space rule: a request is issued only if count < DEPTH after accounting for this cycle's pop. At most one request is outstanding, so a returning ack always has a free slot.
- FSM states:
  - IDLE: if space and no redirect, next state is REQ with mem_req=1 and mem_addr=fetch_pc.
  - REQ, on mem_ack:
    - Push {mem_rdata, fetch_pc+4}; fetch_pc += 4.
    - If space remains after the push and any pop, stay in REQ with mem_addr=new fetch_pc (back-to-back, one fetch per cycle at ack latency 1).
    - Otherwise go to IDLE with mem_req=0.
  - DROP: a cancelled request is still in flight. mem_req stays high on the old address. On mem_ack the data is discarded and the next state is IDLE.
- Output side:
  - instr_valid = (count != 0). instr and pc4 are driven combinationally from the head entry.
  - Pop on a rising edge when instr_valid=1 and stall=0.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Redirect (synchronous, highest priority):
  - FIFO flushed (count=0, pointers=0); fetch_pc <= redirect_pc.
  - The pop in that cycle is suppressed.
  - In REQ without mem_ack: go to DROP. In REQ with mem_ack in the same cycle: data discarded, go to IDLE.
  - In IDLE: stay IDLE, issue on the next cycle.
  - In DROP: update fetch_pc and stay in DROP.
- Redirect together with stall: redirect wins and the queue is flushed.
- fetch_pc arithmetic: 32-bit, wraps at 2^32. Bits [1:0] of mem_addr are forced to 0.

Optional Feature:
- Macro FETCH_QUEUE_STATS_EN.
- When defined, adds outputs stat_fetched[31:0] (count of accepted pushes) and stat_dropped[31:0] (count of discarded acks plus flushed entries, added at the redirect).
  - Both reset to 0 and saturate at 32'hFFFF_FFFF.
- When undefined, these ports and counters do not exist. Functional behaviour is otherwise identical.

Test Plan:
- Reset release, memory acks at latency 1 with stall=0: mem_addr sequence 0x0, 0x4, 0x8, one per cycle. instr_valid rises one cycle after the first ack. pc4 outputs 0x4, 0x8, 0xC in order.
- Hold stall=1, DEPTH=4, latency 1: after 4 pushes mem_req=0 and the FSM is in IDLE. Head stays at pc4=0x4. Releasing stall pops one entry per cycle and requests resume the cycle after the first pop.
- Memory latency 3; redirect to 0x100 one cycle after the request to 0x8 issues: the FSM goes to DROP and mem_addr stays 0x8. The ack data is discarded, then a request to 0x100 follows. The first valid pc4 after the redirect is 0x104.
- Redirect to 0x200 in the same cycle as mem_ack for 0xC: no push, FIFO empty, instr=0, and the next request is to 0x200.
- Assert reset mid-REQ with 2 entries queued: all outputs return to reset values immediately, and after release the first request is to RESET_PC.
- With FETCH_QUEUE_STATS_EN: fetch 5 words, then redirect with 3 queued and 1 in flight: stat_fetched=5, stat_dropped=4.
